tt_sweep: RTL
=============

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter SETTLE, default 2: cycles each vector is held before sampling; legal range 1..15.
REQ-002 Parameter EXPECTED, default 16'h1F55: golden truth table, bit i = expected f_in for vector i, where i = {w,x,y,z} and w is the MSB.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  sweep request; sampled only in IDLE.
REQ-007 abort  input  1  cancels a sweep in progress.
REQ-008 vec_w, vec_x, vec_y, vec_z  output  1 each  registered stimulus to the function-under-test (FUT).
REQ-009 f_in  input  1  FUT output.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE.
REQ-011 done  output  1  one-cycle pulse marking the end of a completed sweep.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 signature  output  16  captured f_in per vector, bit i = vector i.
REQ-014 err_count  output  5  mismatch count, 0..16.
REQ-015 first_err_idx  output  4  index of the first mismatch; valid only when err_count != 0.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETTLE, CAPTURE, DONE.
REQ-017 IDLE + start=1 at edge t: go to SETTLE at t+1 with idx=0 and vec=0; clear signature, err_count, first_err_idx and pass.
REQ-018 SETTLE: hold vec={w,x,y,z}=idx for SETTLE cycles, then go to CAPTURE.
REQ-019 CAPTURE (one cycle): signature[idx] <= f_in; on mismatch with EXPECTED[idx], increment err_count and, if this is the first mismatch, latch idx into first_err_idx.
REQ-020 After CAPTURE: if idx==15 go to DONE; else idx+1 and return to SETTLE, with vec updated in the same edge.
REQ-021 DONE: done=1 for one cycle; pass <= (err_count==0), including any final-vector mismatch; busy=0; next state IDLE.
REQ-022 Latency: done asserts at cycle t+16*(SETTLE+1)+1 (t+49 at default SETTLE).
REQ-023 start while busy SHALL be ignored; no restart and no effect on results.
REQ-024 abort in SETTLE or CAPTURE: next state IDLE; vec=0, busy=0, no done pulse, pass=0; partial signature and err_count held. abort overrides that cycle's capture.
REQ-025 start and abort both high in IDLE: start wins. abort in IDLE or DONE: no effect.
REQ-026 idx SHALL NOT wrap; DONE is the only exit after vector 15.
REQ-027 err_count SHALL saturate at 16 and never exceed it.
REQ-028 signature, err_count, first_err_idx and pass SHALL hold until the next accepted start.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, idx=0, vec outputs 0, busy 0, done 0, pass 0, signature 0, err_count 0, first_err_idx 0.
REQ-030 rst asserted mid-sweep SHALL discard the sweep with no done pulse; after release the block waits for a new start.

Structure
REQ-031 Package tt_sweep_pkg SHALL hold the state enum, VEC_COUNT=16 and the default EXPECTED constant.
REQ-032 One sub-module, tt_settle_timer: 4-bit down-counter with load and zero flag, used for the SETTLE hold.
REQ-033 f_in SHALL be sampled directly with no synchronizer, since the FUT is combinational from registered vec outputs.

Verification
REQ-034 Fault-free FUT connected, start at t -> done at t+49, signature=16'h1F55, err_count=0, pass=1.
REQ-035 f_in tied 0 -> signature=0, err_count=9, first_err_idx=0, pass=0.
REQ-036 f_in tied 1 -> signature=16'hFFFF, err_count=7, first_err_idx=1, pass=0.
REQ-037 abort during vector 5 -> IDLE next cycle, vec=0, busy=0, no done; a following start then gives a full sweep with pass=1.
REQ-038 start pulsed at t+10 during a sweep -> ignored, done still at t+49. rst pulse during vector 8 -> all outputs 0 immediately, no done.
REQ-039 SETTLE=1 override with fault-free FUT -> done at t+33, pass=1.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// The golden table covers all 16 input combinations {w,x,y,z}, w being the MSB.
package tt_sweep_pkg;

  localparam int          VEC_COUNT        = 16;
  localparam logic [15:0] EXPECTED_DEFAULT = 16'h1F55;
  localparam logic [4:0]  ERR_MAX          = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // The count stops at ERR_MAX instead of wrapping back to zero.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 5'd1;
  endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// Signals between the sweep controller and the function-under-test / host.
// The slave modport is the controller side; the master modport is the host/FUT side.
interface tt_sweep_if;

  logic        start;
  logic        abort;
  logic        f_in;
  logic        vec_w;
  logic        vec_x;
  logic        vec_y;
  logic        vec_z;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;

  modport master (
    output start, abort, f_in,
    input  vec_w, vec_x, vec_y, vec_z, busy, done, pass,
           signature, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, f_in,
    output vec_w, vec_x, vec_y, vec_z, busy, done, pass,
           signature, err_count, first_err_idx
  );

endinterface

// File: rtl/tt_settle_timer.sv
// 4-bit loadable down-counter that sets the hold time of each stimulus vector.
// The count stops at zero; zero stays high until the next load.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweep of a 4-input combinational FUT, compared against a golden table.
// Each vector is held for SETTLE cycles, and f_in is sampled in the cycle after that.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start; results of the last sweep are held
//   ST_SETTLE  | vec = idx is driven, waiting for the settle timer
//   ST_CAPTURE | f_in is sampled into signature[idx] and compared
//   ST_DONE    | done pulse and pass are registered, then back to idle
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = EXPECTED_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  tt_sweep_if.slave bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_IDX    = 4'(VEC_COUNT - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] sig_q, sig_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  ferr_q, ferr_d;

  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_zero;
  logic        mismatch;

  tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // f_in is sampled directly: the FUT is combinational from the registered vec outputs.
  assign mismatch = (bus.f_in != EXPECTED[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    sig_d    = sig_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          idx_d    = 4'd0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          sig_d    = 16'd0;
          err_d    = 5'd0;
          ferr_d   = 4'd0;
          tmr_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_CAPTURE: begin
        // An abort here wins over the capture, so the partial results stay untouched.
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          sig_d[idx_q] = bus.f_in;
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (err_q == 5'd0) begin
              ferr_d = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
          end else begin
            state_d  = ST_SETTLE;
            idx_d    = idx_q + 4'd1;
            tmr_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 5'd0);
        idx_d   = 4'd0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= 16'd0;
      err_q   <= 5'd0;
      ferr_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.vec_w         = idx_q[3];
  assign bus.vec_x         = idx_q[2];
  assign bus.vec_y         = idx_q[1];
  assign bus.vec_z         = idx_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.signature     = sig_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = ferr_q;

endmodule
